// File: rtl/sm_imem_arbiter.sv
// Round-robin arbiter sharing one asynchronous instruction ROM among N_REQ fetch requesters.
// A grant registers the word index; the next edge returns the ROM word, error flag and one-hot ack.
module sm_imem_arbiter #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        ack,
  output logic [31:0]             rdata,
  output logic                    err,
  output logic [ADDR_W-1:0]       mem_a,
  input  logic [31:0]             mem_rd
);

  localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [IDX_W-1:0]  last;
  logic [IDX_W-1:0]  gidx;
  logic              align_err;

  logic [N_REQ-1:0]  gidx_onehot;
  logic [N_REQ-1:0]  req_eligible;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [ADDR_W-1:0] sel_addr;
  logic [IDX_W-1:0]  base;
  logic [IDX_W-1:0]  win_idx;
  logic              win_valid;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign addr_arr[gi]    = addr[gi*ADDR_W +: ADDR_W];
    assign gidx_onehot[gi] = (gidx == IDX_W'(gi));
    // The requester being acked at this edge still shows its old req; never re-serve it here.
    assign req_eligible[gi] = req[gi] & ~((state == ACCESS) & gidx_onehot[gi]);
  end

  // In ACCESS the in-flight grant becomes "last" at this same edge, so scan from it.
  assign base = (state == ACCESS) ? gidx : last;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      int c;
      c = (int'(base) + k) % N_REQ;
      if (req_eligible[c]) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  assign sel_addr = addr_arr[win_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      rdata     <= '0;
      err       <= 1'b0;
      mem_a     <= '0;
      last      <= IDX_W'(N_REQ - 1);
      gidx      <= '0;
      align_err <= 1'b0;
    end else begin
      if (state == ACCESS) begin
        rdata <= mem_rd;
        err   <= align_err;
        ack   <= gidx_onehot;
        last  <= gidx;
      end else begin
        ack <= '0;
        err <= 1'b0;
      end
      if (win_valid) begin
        gidx      <= win_idx;
        mem_a     <= {2'b00, sel_addr[ADDR_W-1:2]};
        align_err <= |sel_addr[1:0];
        state     <= ACCESS;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sm_imem_arbiter.sv
// Self-checking bench: a 2-requester and a 4-requester arbiter run side by side against a
// transaction-level round-robin reference model, plus directed scenario checks.
module tb_sm_imem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  rq [2];
  logic [31:0] ad [2][4];

  logic [1:0]   req2, ack2;
  logic [63:0]  addr2;
  logic [31:0]  rdata2, mem_a2, mem_rd2;
  logic         err2;
  logic [3:0]   req4, ack4;
  logic [127:0] addr4;
  logic [31:0]  rdata4, mem_a4, mem_rd4;
  logic         err4;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign req2    = rq[0][1:0];
  assign addr2   = {ad[0][1], ad[0][0]};
  assign req4    = rq[1];
  assign addr4   = {ad[1][3], ad[1][2], ad[1][1], ad[1][0]};
  assign mem_rd2 = rom(mem_a2);
  assign mem_rd4 = rom(mem_a4);

  sm_imem_arbiter #(.N_REQ(2), .ADDR_W(32)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .addr(addr2), .ack(ack2),
    .rdata(rdata2), .err(err2), .mem_a(mem_a2), .mem_rd(mem_rd2)
  );

  sm_imem_arbiter #(.N_REQ(4), .ADDR_W(32)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .addr(addr4), .ack(ack4),
    .rdata(rdata4), .err(err4), .mem_a(mem_a4), .mem_rd(mem_rd4)
  );

  // Reference model: one in-flight grant per arbiter, acked on the following edge.
  int          m_last [2];
  int          m_inf  [2];
  logic [31:0] m_inf_addr [2];
  logic [31:0] m_rdata [2];
  logic [31:0] m_mem_a [2];
  logic        m_err [2];
  logic [3:0]  m_ack [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_last[u]     = (u == 0) ? 1 : 3;
      m_inf[u]      = -1;
      m_inf_addr[u] = '0;
      m_rdata[u]    = '0;
      m_mem_a[u]    = '0;
      m_err[u]      = 1'b0;
      m_ack[u]      = '0;
    end
  endtask

  task automatic model_step();
    int n, done, w, c;
    logic [3:0] elig;
    for (int u = 0; u < 2; u++) begin
      n    = (u == 0) ? 2 : 4;
      done = m_inf[u];
      if (done >= 0) begin
        m_ack[u]   = 4'(1 << done);
        m_rdata[u] = rom(m_inf_addr[u] >> 2);
        m_err[u]   = |m_inf_addr[u][1:0];
        m_last[u]  = done;
      end else begin
        m_ack[u] = '0;
        m_err[u] = 1'b0;
      end
      elig = rq[u] & ((u == 0) ? 4'b0011 : 4'b1111);
      if (done >= 0) elig[done] = 1'b0;
      w = -1;
      for (int k = 1; k <= n; k++) begin
        c = (m_last[u] + k) % n;
        if (w < 0 && elig[c]) w = c;
      end
      m_inf[u] = w;
      if (w >= 0) begin
        m_inf_addr[u] = ad[u][w];
        m_mem_a[u]    = ad[u][w] >> 2;
      end
    end
  endtask

  // Advance one clock, then compare both arbiters with the model.
  task automatic tick();
    logic [3:0]  a;
    logic [31:0] r, ma;
    logic        e;
    if (rst) model_reset();
    else     model_step();
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      a  = (u == 0) ? {2'b00, ack2} : ack4;
      r  = (u == 0) ? rdata2 : rdata4;
      ma = (u == 0) ? mem_a2 : mem_a4;
      e  = (u == 0) ? err2 : err4;
      if (a != 0)
        $display("u%0d ack=%b rdata=%h err=%b mem_a=%h", u, a, r, e, ma);
      n_checks += 4;
      if (a !== m_ack[u]) begin
        n_fail++;
        $display("FAIL model_ack u%0d: got %b expected %b at %0t", u, a, m_ack[u], $time);
      end
      if (r !== m_rdata[u]) begin
        n_fail++;
        $display("FAIL model_rdata u%0d: got %h expected %h at %0t", u, r, m_rdata[u], $time);
      end
      if (e !== m_err[u]) begin
        n_fail++;
        $display("FAIL model_err u%0d: got %b expected %b at %0t", u, e, m_err[u], $time);
      end
      if (ma !== m_mem_a[u]) begin
        n_fail++;
        $display("FAIL model_mem_a u%0d: got %h expected %h at %0t", u, ma, m_mem_a[u], $time);
      end
    end
  endtask

  task automatic test_reset();
    rq[0] = 4'b0011;
    ad[0][0] = 32'h20;
    ad[0][1] = 32'h44;
    tick();
    tick();
    n_checks++;
    if ({ack2, ack4, err2, err4} !== 8'h00 || rdata2 !== 0 || mem_a2 !== 0 || mem_a4 !== 0) begin
      n_fail++;
      $display("FAIL reset_values: got ack2=%b ack4=%b err=%b%b rdata2=%h mem_a2=%h expected all zero",
               ack2, ack4, err2, err4, rdata2, mem_a2);
    end
    rst = 1'b0;
  endtask

  task automatic test_release_order();
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || mem_a2 !== 32'h8) begin
      n_fail++;
      $display("FAIL first_grant: got ack=%b mem_a=%h expected ack=00 mem_a=8", ack2, mem_a2);
    end
    tick();
    n_checks++;
    if (ack2 !== 2'b01 || rdata2 !== rom(32'h8)) begin
      n_fail++;
      $display("FAIL first_ack: got ack=%b rdata=%h expected ack=01 rdata=%h", ack2, rdata2, rom(32'h8));
    end
    rq[0][0] = 1'b0;
    tick();
    n_checks++;
    if (ack2 !== 2'b10 || rdata2 !== rom(32'h11)) begin
      n_fail++;
      $display("FAIL second_ack: got ack=%b rdata=%h expected ack=10 rdata=%h", ack2, rdata2, rom(32'h11));
    end
    rq[0][1] = 1'b0;
    tick();
  endtask

  task automatic test_single();
    rq[0] = 4'b0010;
    ad[0][1] = 32'h10;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_checks++;
      if (ack2 !== 2'b00 || mem_a2 !== 32'(4 + j)) begin
        n_fail++;
        $display("FAIL single_grant %0d: got ack=%b mem_a=%h expected ack=00 mem_a=%h", j, ack2, mem_a2, 4 + j);
      end
      tick();
      n_checks++;
      if (ack2 !== 2'b10 || rdata2 !== rom(32'(4 + j))) begin
        n_fail++;
        $display("FAIL single_ack %0d: got ack=%b rdata=%h expected ack=10 rdata=%h", j, ack2, rdata2, rom(32'(4 + j)));
      end
      ad[0][1] = ad[0][1] + 32'd4;
    end
    rq[0] = 4'b0000;
    tick();
  endtask

  task automatic test_back_to_back();
    int prev, cnt, cyc, idx;
    logic [1:0] expv;
    rq[0] = 4'b0011;
    ad[0][0] = {$urandom_range(0, 4095), 2'b00};
    ad[0][1] = {$urandom_range(0, 4095), 2'b00};
    prev = -1;
    cnt  = 0;
    cyc  = 0;
    while (cnt < 8 && cyc < 40) begin
      tick();
      cyc++;
      if (ack2 != 2'b00) begin
        expv = (prev < 0) ? 2'b01 : 2'(1 << (prev ^ 1));
        n_checks++;
        if (ack2 !== expv) begin
          n_fail++;
          $display("FAIL alternate %0d: got ack=%b expected %b", cnt, ack2, expv);
        end
        idx  = ack2[1] ? 1 : 0;
        prev = idx;
        cnt++;
        ad[0][idx] = {$urandom_range(0, 4095), 2'b00};
      end else if (prev >= 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL throughput_gap: got ack=00 expected an ack every cycle at %0t", $time);
      end
    end
    n_checks++;
    if (cnt < 8) begin
      n_fail++;
      $display("FAIL alternate_timeout: got %0d acks expected 8", cnt);
    end
    rq[0] = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_misaligned();
    rq[0] = 4'b0001;
    ad[0][0] = 32'h6;
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || mem_a2 !== 32'h1) begin
      n_fail++;
      $display("FAIL misalign_grant: got ack=%b mem_a=%h expected ack=00 mem_a=1", ack2, mem_a2);
    end
    tick();
    n_checks++;
    if (ack2 !== 2'b01 || err2 !== 1'b1 || rdata2 !== rom(32'h1)) begin
      n_fail++;
      $display("FAIL misalign_ack: got ack=%b err=%b rdata=%h expected ack=01 err=1 rdata=%h",
               ack2, err2, rdata2, rom(32'h1));
    end
    ad[0][0] = 32'h8;
    tick();
    tick();
    n_checks++;
    if (ack2 !== 2'b01 || err2 !== 1'b0 || rdata2 !== rom(32'h2)) begin
      n_fail++;
      $display("FAIL aligned_after: got ack=%b err=%b rdata=%h expected ack=01 err=0 rdata=%h",
               ack2, err2, rdata2, rom(32'h2));
    end
    rq[0] = 4'b0000;
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL err_without_ack: got ack=%b err=%b expected ack=00 err=0", ack2, err2);
    end
  endtask

  task automatic test_reset_mid_access();
    rq[0] = 4'b0001;
    ad[0][0] = 32'h30;
    tick();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (ack2 !== 2'b00 || mem_a2 !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got ack=%b mem_a=%h expected ack=00 mem_a=0", ack2, mem_a2);
    end
    rq[0] = 4'b0010;
    ad[0][1] = 32'h50;
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (ack2 !== 2'b00 || mem_a2 !== 32'h14) begin
      n_fail++;
      $display("FAIL post_reset_grant: got ack=%b mem_a=%h expected ack=00 mem_a=14", ack2, mem_a2);
    end
    tick();
    n_checks++;
    if (ack2 !== 2'b10 || rdata2 !== rom(32'h14)) begin
      n_fail++;
      $display("FAIL post_reset_ack: got ack=%b rdata=%h expected ack=10 rdata=%h", ack2, rdata2, rom(32'h14));
    end
    rq[0] = 4'b0000;
    tick();
  endtask

  task automatic test_rr4();
    rq[1] = 4'b0010;
    ad[1][1] = 32'h100;
    tick();
    tick();
    rq[1] = 4'b0000;
    tick();
    rq[1] = 4'b1010;
    ad[1][3] = 32'h300;
    ad[1][1] = 32'h104;
    tick();
    n_checks++;
    if (ack4 !== 4'b0000 || mem_a4 !== 32'hC0) begin
      n_fail++;
      $display("FAIL rr4_grant3: got ack=%b mem_a=%h expected ack=0000 mem_a=c0", ack4, mem_a4);
    end
    tick();
    n_checks++;
    if (ack4 !== 4'b1000 || rdata4 !== rom(32'hC0)) begin
      n_fail++;
      $display("FAIL rr4_ack3: got ack=%b rdata=%h expected ack=1000 rdata=%h", ack4, rdata4, rom(32'hC0));
    end
    rq[1][3] = 1'b0;
    tick();
    n_checks++;
    if (ack4 !== 4'b0010 || rdata4 !== rom(32'h41)) begin
      n_fail++;
      $display("FAIL rr4_ack1: got ack=%b rdata=%h expected ack=0010 rdata=%h", ack4, rdata4, rom(32'h41));
    end
    ad[1][1] = 32'h108;
    rq[1][0] = 1'b1;
    ad[1][0] = 32'h200;
    tick();
    n_checks++;
    if (ack4 !== 4'b0000 || mem_a4 !== 32'h80) begin
      n_fail++;
      $display("FAIL rr4_grant0: got ack=%b mem_a=%h expected ack=0000 mem_a=80", ack4, mem_a4);
    end
    tick();
    n_checks++;
    if (ack4 !== 4'b0001 || rdata4 !== rom(32'h80)) begin
      n_fail++;
      $display("FAIL rr4_ack0: got ack=%b rdata=%h expected ack=0001 rdata=%h", ack4, rdata4, rom(32'h80));
    end
    rq[1][0] = 1'b0;
    tick();
    n_checks++;
    if (ack4 !== 4'b0010 || rdata4 !== rom(32'h42)) begin
      n_fail++;
      $display("FAIL rr4_ack1_again: got ack=%b rdata=%h expected ack=0010 rdata=%h", ack4, rdata4, rom(32'h42));
    end
    rq[1] = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] a;
    int n;
    for (int cyc = 0; cyc < 300; cyc++) begin
      tick();
      for (int u = 0; u < 2; u++) begin
        n = (u == 0) ? 2 : 4;
        a = (u == 0) ? {2'b00, ack2} : ack4;
        n_checks++;
        if ((a & (a - 4'd1)) != 4'd0) begin
          n_fail++;
          $display("FAIL ack_onehot u%0d: got ack=%b expected at most one bit", u, a);
        end
        for (int i = 0; i < n; i++) begin
          if (rq[u][i] && a[i]) begin
            if ($urandom_range(0, 1) == 1) ad[u][i] = $urandom;
            else rq[u][i] = 1'b0;
          end else if (!rq[u][i]) begin
            if ($urandom_range(0, 2) == 0) begin
              rq[u][i] = 1'b1;
              ad[u][i] = $urandom;
            end
          end else if ($urandom_range(0, 31) == 0) begin
            rq[u][i] = 1'b0;
          end
        end
      end
    end
    rq[0] = 4'b0000;
    rq[1] = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      rq[u] = 4'b0000;
      for (int i = 0; i < 4; i++) ad[u][i] = '0;
    end
    model_reset();
    test_reset();
    test_release_order();
    test_single();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_access();
    test_rr4();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
